// File: rtl/reg_bank_ctrl_if.sv
// Request/response handshake and register-bank bus for reg_bank_ctrl.
// slave = controller side, master = requester plus the register bank.
interface reg_bank_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [2:0] req_rs;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_rs;
  logic [7:0] rsp_data;
  logic [2:0] RS;
  logic       RW;
  logic       En;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       busy;

  modport master (
    output req_valid, req_rw, req_rs, req_data, rsp_ready, Dout,
    input  req_ready, rsp_valid, rsp_rs, rsp_data, RS, RW, En, Din, busy
  );

  modport slave (
    input  req_valid, req_rw, req_rs, req_data, rsp_ready, Dout,
    output req_ready, rsp_valid, rsp_rs, rsp_data, RS, RW, En, Din, busy
  );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Queued register-bank controller: FIFO of requests, one bank access at a time.
// Define REG_BANK_CTRL_WRACK_EN to make writes return a response as well.
module reg_bank_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       rw;
    logic [2:0] rs;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t       r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  state_t     r_state;
  logic [1:0] r_wcnt;
  logic       r_en, r_rw;
  logic [2:0] r_rs;
  logic [7:0] r_din;
  logic       r_rsp_valid;
  logic [2:0] r_rsp_rs;
  logic [7:0] r_rsp_data;

  logic w_empty, w_full, w_ready, w_push, w_pop;
  req_t w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_ready = !rst && !w_full;
  assign w_push  = bus.req_valid && w_ready;
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= '{rw: bus.req_rw, rs: bus.req_rs, data: bus.req_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_en        <= 1'b0;
      r_rw        <= 1'b1;
      r_rs        <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rs    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          r_en    <= 1'b1;
          r_rw    <= w_head.rw;
          r_rs    <= w_head.rs;
          r_din   <= w_head.data;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_en   <= 1'b0;
          r_rw   <= 1'b1;
          r_rs   <= '0;
          r_din  <= '0;
          r_wcnt <= '0;
          if (r_rw) begin
            r_state <= WAIT;
          end else begin
`ifdef REG_BANK_CTRL_WRACK_EN
            r_rsp_valid <= 1'b1;
            r_rsp_rs    <= r_rs;
            r_rsp_data  <= r_din;
            r_state     <= RESP;
`else
            r_state <= IDLE;
`endif
          end
        end
        WAIT: begin
          // Dout is valid in the last of READ_LAT wait cycles.
          if (r_wcnt == 2'(READ_LAT-1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.Dout;
            r_state     <= RESP;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // rsp_rs tracks the issued target; it is only observable with rsp_valid.
      if (r_state == ISSUE && r_rw) r_rsp_rs <= r_rs;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rs    = r_rsp_rs;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.En        = r_en;
  assign bus.RW        = r_rw;
  assign bus.RS        = r_rs;
  assign bus.Din       = r_din;
  assign bus.busy      = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: vector table plus scoreboard queues
// for bank accesses and responses, with hand sequences for the corner cases.
`timescale 1ns/1ps
module tb_reg_bank_ctrl;
  localparam int DEPTH = 4;
  localparam int RL    = 2;
`ifdef REG_BANK_CTRL_WRACK_EN
  localparam int WRACK = 1;
`else
  localparam int WRACK = 0;
`endif

  typedef struct {
    logic       rw;
    logic [2:0] rs;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  typedef struct {
    logic       rw;
    logic [2:0] rs;
    logic [7:0] data;
  } acc_t;
  typedef struct {
    logic [2:0] rs;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_ctrl_if b();
  reg_bank_ctrl #(.FIFO_DEPTH(DEPTH), .READ_LAT(RL)) dut (.clk(clk), .rst(rst), .bus(b));

  // Register bank model: Dout valid RL cycles after the En cycle, 0 otherwise.
  logic [7:0] bank [8];
  logic [7:0] rd_pipe [RL];
  assign b.Dout = rd_pipe[RL-1];
  always @(posedge clk) begin
    if (b.En && !b.RW) bank[b.RS] <= b.Din;
    rd_pipe[0] <= (b.En && b.RW) ? bank[b.RS] : 8'h00;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int checks = 0, errors = 0, cyc = 0, en_cnt = 0, rsp_cnt = 0;
  int last_en_cyc = 0;
  logic last_en_rw = 1'b0;
  logic prev_en = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [2:0] prev_rs = '0;
  logic [7:0] prev_data = '0;
  bit saw_full = 0;
  acc_t exp_acc [$];
  rsp_t exp_rsp [$];
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    acc_t a;
    rsp_t r;
    cyc++;
    if (rst) begin
      prev_en = 0; prev_rv = 0; prev_rr = 0;
    end else begin
      if (b.En) begin
        chk("en_single", prev_en, 0);
        if (exp_acc.size() == 0) chk("en_unexpected", 1, 0);
        else begin
          a = exp_acc.pop_front();
          chk("bank_rw", b.RW, a.rw);
          chk("bank_rs", b.RS, a.rs);
          if (!a.rw) chk("bank_din", b.Din, a.data);
        end
        last_en_cyc = cyc;
        last_en_rw  = b.RW;
        en_cnt++;
      end else begin
        chk("bank_idle", {b.RW, b.RS, b.Din}, 12'h800);
      end
      if (b.rsp_valid && !prev_rv)
        chk("rsp_latency", cyc - last_en_cyc, last_en_rw ? RL + 1 : 1);
      if (b.rsp_valid && prev_rv && !prev_rr)
        chk("rsp_hold", {b.rsp_rs, b.rsp_data}, {prev_rs, prev_data});
      if (b.rsp_valid && b.rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_rs", b.rsp_rs, r.rs);
          chk("rsp_data", b.rsp_data, r.data);
        end
        rsp_cnt++;
      end
      prev_en = b.En; prev_rv = b.rsp_valid; prev_rr = b.rsp_ready;
      prev_rs = b.rsp_rs; prev_data = b.rsp_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [2:0] rs, input logic [7:0] data,
                      input logic [7:0] exp);
    bit ok = 0;
    b.req_valid = 1'b1; b.req_rw = rw; b.req_rs = rs; b.req_data = data;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = b.req_ready;
      if (ok) begin
        exp_acc.push_back('{rw, rs, data});
        if (rw) exp_rsp.push_back('{rs, exp});
        else if (WRACK != 0) exp_rsp.push_back('{rs, data});
      end else begin
        saw_full = 1;
      end
      step();
    end
    b.req_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (!b.busy && !b.rsp_valid && exp_acc.size() == 0 && exp_rsp.size() == 0) done = 1;
      else step();
    end
    chk("drain", done, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0;
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b0, 3'(i), 8'(8'hF1 + i), 8'h00};
      tbl[i + 8] = '{1'b1, 3'(i), 8'h00, 8'(8'hF1 + i)};
    end
    b.req_valid = 0; b.req_rw = 0; b.req_rs = '0; b.req_data = '0; b.rsp_ready = 1;

    // Reset
    #1;
    chk("ready_in_reset", b.req_ready, 0);
    step();
    chk("rst_bank", {b.En, b.RW, b.RS, b.Din}, 13'h0800);
    chk("rst_rsp", {b.rsp_valid, b.rsp_rs, b.rsp_data}, 12'h000);
    chk("rst_busy", b.busy, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", b.req_ready, 1);

    // Back-to-back writes, then reads of the same registers
    e0 = en_cnt; saw_full = 0;
    for (int i = 0; i < 8; i++) send(tbl[i].rw, tbl[i].rs, tbl[i].data, tbl[i].exp);
    chk("queue_filled", saw_full, 1);
    wait_idle();
    chk("write_en_count", en_cnt - e0, 8);
    r0 = rsp_cnt;
    for (int i = 8; i < 16; i++) send(tbl[i].rw, tbl[i].rs, tbl[i].data, tbl[i].exp);
    wait_idle();
    chk("read_rsp_count", rsp_cnt - r0, 8);

    // Push-to-En and En-to-rsp_valid latency from idle
    send(1'b1, 3'd1, 8'h00, 8'hF2);
    chk("lat_en_early", b.En, 0);
    step();
    chk("lat_en", b.En, 1);
    for (int i = 0; i < RL; i++) begin
      step();
      chk("lat_rsp_early", b.rsp_valid, 0);
    end
    step();
    chk("lat_rsp", b.rsp_valid, 1);
    wait_idle();

    // Response backpressure: queue fills, bank stays quiet, response held
    b.rsp_ready = 0;
    send(1'b1, 3'd3, 8'h00, 8'hF4);
    for (int n = 0; n < 50 && !b.rsp_valid; n++) step();
    chk("bp_rsp_up", b.rsp_valid, 1);
    send(1'b1, 3'd0, 8'h00, 8'hF1);
    send(1'b1, 3'd1, 8'h00, 8'hF2);
    send(1'b1, 3'd2, 8'h00, 8'hF3);
    send(1'b1, 3'd7, 8'h00, 8'hF8);
    chk("bp_ready_low", b.req_ready, 0);
    e0 = en_cnt;
    repeat (10) step();
    chk("bp_no_en", en_cnt - e0, 0);
    chk("bp_hold", {b.rsp_valid, b.rsp_rs, b.rsp_data}, {1'b1, 3'd3, 8'hF4});
    chk("bp_busy", b.busy, 1);
    b.rsp_ready = 1;
    wait_idle();

    // Write acknowledge only with the macro; read back the written value
    r0 = rsp_cnt;
    send(1'b0, 3'd5, 8'hA5, 8'h00);
    wait_idle();
    chk("wrack_count", rsp_cnt - r0, WRACK);
    send(1'b1, 3'd5, 8'h00, 8'hA5);
    wait_idle();

    // Reset in the last WAIT cycle with three requests queued
    send(1'b1, 3'd6, 8'h00, 8'hF7);
    send(1'b0, 3'd0, 8'h11, 8'h00);
    send(1'b0, 3'd1, 8'h22, 8'h00);
    send(1'b0, 3'd2, 8'h33, 8'h00);
    chk("pre_rst_busy", {b.busy, b.rsp_valid, b.En}, 3'b100);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", b.req_ready, 0);
    step();
    rst = 1'b0;
    exp_acc.delete();
    exp_rsp.delete();
    chk("rst_mid_state", {b.En, b.rsp_valid, b.busy}, 3'b000);
    e0 = en_cnt; r0 = rsp_cnt;
    repeat (20) step();
    chk("rst_mid_no_en", en_cnt - e0, 0);
    chk("rst_mid_no_rsp", rsp_cnt - r0, 0);
    chk("rst_mid_idle", {b.busy, b.req_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
